trace_calc_param: RTL and testbench



---
 rtl/trace_calc_param.sv | 221 ++++++++++++++++++++++
 tb/tb_trace_calc_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_calc_param.sv
// Trace engine: one sequential sweep over the Y/G RAMs computes trace(Y^H G) (or trace(Y^T G))
// and ||G||_F^2. Results are Q-scaled, rounded half-up, saturated and held until the next run.
module trace_calc_param #(
  parameter int N         = 16,
  parameter int Q         = 8,
  parameter int NR        = 4,
  parameter int NT        = 2,
  parameter int ACC_WIDTH = 40,
  parameter int AW        = $clog2(NR*NT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          conj_en,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [N-1:0]  y_rd_data_r,
  input  logic [N-1:0]  y_rd_data_i,
  input  logic [N-1:0]  g_rd_data_r,
  input  logic [N-1:0]  g_rd_data_i,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  trace_r,
  output logic [N-1:0]  trace_i,
  output logic [N-1:0]  energy,
  output logic          ovf,
  output logic [2:0]    state_dbg
);

  localparam int M  = NR * NT;
  localparam int PW = 2 * N + 1;
  localparam int AX = ACC_WIDTH + 1;

  localparam logic signed [AX-1:0] HALF = {{(AX-1){1'b0}}, 1'b1} << (Q - 1);
  localparam logic signed [AX-1:0] MAXV = {{(AX-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AX-1:0] MINV = ~MAXV;
  localparam logic signed [AX-1:0] ZERO = '0;

  // Handshake: start is sampled only in IDLE or DONE and is ignored otherwise; done is a
  // single-cycle pulse in the DONE state, and results stay stable from then until the next FINAL.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          conj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q walks the element address in READ and counts the two drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_READ: begin
        if (cnt_q == AW'(M - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == AW'(1)) begin
          state_d = S_FINAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_FINAL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) accept = 1'b1;
        else       state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      state_d = S_READ;
      cnt_d   = '0;
    end
  end

  assign rd_en     = (state_q == S_READ);
  assign rd_addr   = rd_en ? cnt_q : '0;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_FINAL);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         conj_q <= 1'b0;
    else if (accept) conj_q <= conj_en;
  end

  // Product stage operands
  logic signed [N-1:0]   yr, yi, gr, gi;
  logic signed [2*N-1:0] m_yr_gr, m_yi_gi, m_yr_gi, m_yi_gr, m_gr_gr, m_gi_gi;
  logic signed [PW-1:0]  pr_d, pi_d, pe_d;

  assign yr = y_rd_data_r;
  assign yi = y_rd_data_i;
  assign gr = g_rd_data_r;
  assign gi = g_rd_data_i;

  assign m_yr_gr = yr * gr;
  assign m_yi_gi = yi * gi;
  assign m_yr_gi = yr * gi;
  assign m_yi_gr = yi * gr;
  assign m_gr_gr = gr * gr;
  assign m_gi_gi = gi * gi;

  always_comb begin
    pr_d = '0;
    pi_d = '0;
    if (conj_q) begin
      pr_d = PW'(m_yr_gr) + PW'(m_yi_gi);
      pi_d = PW'(m_yr_gi) - PW'(m_yi_gr);
    end else begin
      pr_d = PW'(m_yr_gr) - PW'(m_yi_gi);
      pi_d = PW'(m_yr_gi) + PW'(m_yi_gr);
    end
    pe_d = PW'(m_gr_gr) + PW'(m_gi_gi);
  end

  // dv_q marks the cycle in which RAM data for an issued address is present.
  logic                        dv_q, pv_q;
  logic signed [PW-1:0]        p_r_q, p_i_q, p_e_q;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_i, acc_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q  <= 1'b0;
      pv_q  <= 1'b0;
      p_r_q <= '0;
      p_i_q <= '0;
      p_e_q <= '0;
    end else begin
      dv_q <= rd_en;
      pv_q <= dv_q;
      if (dv_q) begin
        p_r_q <= pr_d;
        p_i_q <= pi_d;
        p_e_q <= pe_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      acc_i <= '0;
      acc_e <= '0;
    end else if (accept) begin
      acc_r <= '0;
      acc_i <= '0;
      acc_e <= '0;
    end else if (pv_q) begin
      acc_r <= acc_r + ACC_WIDTH'(p_r_q);
      acc_i <= acc_i + ACC_WIDTH'(p_i_q);
      acc_e <= acc_e + ACC_WIDTH'(p_e_q);
    end
  end

  // Returns {clipped, value}; one extra accumulator bit keeps the +HALF from wrapping.
  function automatic logic [N:0] sat_fn(input logic signed [AX-1:0] v,
                                        input logic signed [AX-1:0] lo);
    if (v > MAXV)      return {1'b1, MAXV[N-1:0]};
    else if (v < lo)   return {1'b1, lo[N-1:0]};
    else               return {1'b0, v[N-1:0]};
  endfunction

  logic signed [AX-1:0] rnd_r, rnd_i, rnd_e;
  logic [N:0]           sat_r, sat_i, sat_e;

  assign rnd_r = (AX'(acc_r) + HALF) >>> Q;
  assign rnd_i = (AX'(acc_i) + HALF) >>> Q;
  assign rnd_e = (AX'(acc_e) + HALF) >>> Q;
  assign sat_r = sat_fn(rnd_r, MINV);
  assign sat_i = sat_fn(rnd_i, MINV);
  assign sat_e = sat_fn(rnd_e, ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_r <= '0;
      trace_i <= '0;
      energy  <= '0;
      ovf     <= 1'b0;
    end else if (state_q == S_FINAL) begin
      trace_r <= sat_r[N-1:0];
      trace_i <= sat_i[N-1:0];
      energy  <= sat_e[N-1:0];
      ovf     <= sat_r[N] | sat_i[N] | sat_e[N];
    end else if (accept) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_calc_param.sv
// Bench for trace_calc_param: directed matrices, a matrix-level reference model checked every
// cycle, literal pins for the documented cases, and a small NR=2/NT=1 instance.
module tb_trace_calc_param;
  localparam int N  = 16;
  localparam int Q  = 8;
  localparam int NR = 4;
  localparam int NT = 2;
  localparam int M  = NR * NT;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic conj_en = 1'b0;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0] y_rd_data_r = '0, y_rd_data_i = '0, g_rd_data_r = '0, g_rd_data_i = '0;
  logic busy, done, ovf;
  logic [N-1:0] trace_r, trace_i, energy;
  logic [2:0] state_dbg;

  logic start2 = 1'b0;
  logic rd_en2;
  logic [0:0] rd_addr2;
  logic [N-1:0] d2_r = '0;
  logic [N-1:0] d2_i = '0;
  logic busy2, done2, ovf2;
  logic [N-1:0] trace2_r, trace2_i, energy2;
  logic [2:0] state_dbg2;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  logic signed [N-1:0] my_r[M], my_i[M], mg_r[M], mg_i[M];

  trace_calc_param #(.N(N), .Q(Q), .NR(NR), .NT(NT), .ACC_WIDTH(40)) u_dut (
    .clk(clk), .rst(rst), .start(start), .conj_en(conj_en),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .y_rd_data_r(y_rd_data_r), .y_rd_data_i(y_rd_data_i),
    .g_rd_data_r(g_rd_data_r), .g_rd_data_i(g_rd_data_i),
    .busy(busy), .done(done), .trace_r(trace_r), .trace_i(trace_i),
    .energy(energy), .ovf(ovf), .state_dbg(state_dbg)
  );

  trace_calc_param #(.N(N), .Q(Q), .NR(2), .NT(1), .ACC_WIDTH(40)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .conj_en(1'b1),
    .rd_en(rd_en2), .rd_addr(rd_addr2),
    .y_rd_data_r(d2_r), .y_rd_data_i(d2_i),
    .g_rd_data_r(d2_r), .g_rd_data_i(d2_i),
    .busy(busy2), .done(done2), .trace_r(trace2_r), .trace_i(trace2_i),
    .energy(energy2), .ovf(ovf2), .state_dbg(state_dbg2)
  );

  // ---------------- clock / RAMs ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      y_rd_data_r <= my_r[rd_addr];
      y_rd_data_i <= my_i[rd_addr];
      g_rd_data_r <= mg_r[rd_addr];
      g_rd_data_i <= mg_i[rd_addr];
    end
    if (rd_en2) d2_r <= 16'd256;
  end

  // ---------------- scoreboard helpers ----------------
  function automatic longint sx(input logic [N-1:0] v);
    logic signed [N-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint rnd_sat(input longint acc, input longint lo, output bit clip);
    longint v;
    v = (acc + (longint'(1) <<< (Q - 1))) >>> Q;
    clip = 1'b0;
    if (v > 32767) begin clip = 1'b1; return 32767; end
    if (v < lo)    begin clip = 1'b1; return lo; end
    return v;
  endfunction

  int     since = -1;
  longint e_tr = 0, e_ti = 0, e_en = 0;
  bit     e_ovf = 1'b0;
  longint p_tr, p_ti, p_en;
  bit     p_ovf;

  task automatic model_calc(input bit cj);
    longint sr, si, se;
    bit c0, c1, c2;
    sr = 0; si = 0; se = 0;
    for (int k = 0; k < M; k++) begin
      longint a, b, c, d;
      a = my_r[k]; b = my_i[k]; c = mg_r[k]; d = mg_i[k];
      if (cj) begin
        sr += a * c + b * d;
        si += a * d - b * c;
      end else begin
        sr += a * c - b * d;
        si += a * d + b * c;
      end
      se += c * c + d * d;
    end
    p_tr  = rnd_sat(sr, -32768, c0);
    p_ti  = rnd_sat(si, -32768, c1);
    p_en  = rnd_sat(se, 0, c2);
    p_ovf = c0 | c1 | c2;
  endtask

  // since = clock edges elapsed since the accepting edge; -1 when no operation is tracked
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since = -1;
      e_tr = 0; e_ti = 0; e_en = 0; e_ovf = 1'b0;
    end else if ((since < 0 || since == M + 3) && start) begin
      since = 0;
      e_ovf = 1'b0;
      model_calc(conj_en);
    end else if (since >= 0 && since < M + 3) begin
      since++;
      if (since == M + 3) begin
        e_tr = p_tr; e_ti = p_ti; e_en = p_en; e_ovf = p_ovf;
      end
    end else begin
      since = -1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("busy", busy, since >= 0 && since <= M + 2);
      chk("done", done, since == M + 3);
      chk("rd_en", rd_en, since >= 0 && since < M);
      chk("rd_addr", rd_addr, (since >= 0 && since < M) ? since : 0);
      chk("trace_r", sx(trace_r), e_tr);
      chk("trace_i", sx(trace_i), e_ti);
      chk("energy", energy, e_en);
      chk("ovf", ovf, e_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_all(input int yr, input int yi, input int gr, input int gi);
    for (int k = 0; k < M; k++) begin
      my_r[k] = N'(yr); my_i[k] = N'(yi); mg_r[k] = N'(gr); mg_i[k] = N'(gi);
    end
  endtask

  task automatic run_op(input bit cj, input int pulse_at, output int lat,
                        output int busy_cyc, output int rd_cyc);
    int n;
    @(negedge clk);
    start = 1'b1;
    conj_en = cj;
    n = 0; busy_cyc = 0; rd_cyc = 0;
    do begin
      @(negedge clk);
      n++;
      start = (pulse_at != 0 && n == pulse_at);
      if (busy)  busy_cyc++;
      if (rd_en) rd_cyc++;
    end while (!done && n < 40);
    start = 1'b0;
    lat = n - 1;
  endtask

  task automatic run_simple(input bit cj, input string tag);
    int lat, bc, rc;
    run_op(cj, 0, lat, bc, rc);
    chk({tag, "_latency"}, lat, M + 3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, bc, rc, n;
    load_all(0, 0, 0, 0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_trace_r", trace_r, 0);
    chk("rst_energy", energy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // unity matrices
    load_all(256, 0, 256, 0);
    run_op(1'b1, 0, lat, bc, rc);
    chk("t1_latency", lat, 11);
    chk("t1_busy_cycles", bc, 11);
    chk("t1_rd_cycles", rc, 8);
    chk("t1_trace_r", sx(trace_r), 2048);
    chk("t1_trace_i", sx(trace_i), 0);
    chk("t1_energy", energy, 2048);
    chk("t1_ovf", ovf, 0);

    // conjugation mode
    load_all(0, 256, 0, 256);
    run_simple(1'b1, "t2c");
    chk("t2_conj_trace_r", sx(trace_r), 2048);
    chk("t2_conj_energy", energy, 2048);
    run_simple(1'b0, "t2n");
    chk("t2_noconj_trace_r", sx(trace_r), -2048);
    chk("t2_noconj_trace_i", sx(trace_i), 0);
    chk("t2_noconj_energy", energy, 2048);

    // rounding
    load_all(0, 0, 0, 0);
    my_r[0] = 16'sd1; mg_r[0] = 16'sd128;
    run_simple(1'b1, "t3a");
    chk("t3_round_up", sx(trace_r), 1);
    my_r[0] = -16'sd1;
    run_simple(1'b1, "t3b");
    chk("t3_round_neg", sx(trace_r), 0);

    // mixed per-element data, both modes
    for (int k = 0; k < M; k++) begin
      my_r[k] = N'(k * 37 - 100); my_i[k] = N'(50 - k * 11);
      mg_r[k] = N'(300 - k * 29); mg_i[k] = N'(k * 13 - 40);
    end
    run_simple(1'b1, "mix_c");
    run_simple(1'b0, "mix_n");

    // saturation, then zeros clears ovf
    load_all(32767, 32767, 32767, 32767);
    run_simple(1'b1, "t4s");
    chk("t4_sat_trace_r", sx(trace_r), 32767);
    chk("t4_sat_trace_i", sx(trace_i), 0);
    chk("t4_sat_energy", energy, 32767);
    chk("t4_sat_ovf", ovf, 1);
    load_all(0, 0, 0, 0);
    run_simple(1'b1, "t4z");
    chk("t4_zero_trace_r", sx(trace_r), 0);
    chk("t4_zero_energy", energy, 0);
    chk("t4_zero_ovf", ovf, 0);

    // start pulse during READ is ignored
    load_all(256, 0, 256, 0);
    run_op(1'b1, 3, lat, bc, rc);
    chk("t5_pulse_latency", lat, 11);
    chk("t5_pulse_trace_r", sx(trace_r), 2048);
    repeat (4) @(negedge clk);
    chk("t5_pulse_no_extra_done", done, 0);

    // reset mid-READ
    @(negedge clk);
    start = 1'b1; conj_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd_en", rd_en, 0);
    chk("t5_rst_rd_addr", rd_addr, 0);
    chk("t5_rst_trace_r", trace_r, 0);
    chk("t5_rst_energy", energy, 0);
    chk("t5_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // start held through DONE: next READ follows immediately
    @(negedge clk);
    start = 1'b1; conj_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk("t5_b2b_first_latency", n - 1, 11);
    @(negedge clk);
    chk("t5_b2b_busy", busy, 1);
    chk("t5_b2b_rd_en", rd_en, 1);
    chk("t5_b2b_rd_addr", rd_addr, 0);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("t5_b2b_second_latency", n - 1, 11);
    chk("t5_b2b_trace_r", sx(trace_r), 2048);

    // NR=2, NT=1 variant
    @(negedge clk);
    start2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start2 = 1'b0;
    end while (!done2 && n < 20);
    chk("t6_latency", n - 1, 5);
    chk("t6_trace_r", sx(trace2_r), 512);
    chk("t6_trace_i", sx(trace2_i), 0);
    chk("t6_energy", energy2, 512);
    chk("t6_ovf", ovf2, 0);

    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
